// File: rtl/cic_d_seq.sv
// cic_d_seq: run-control sequencer pacing samples into a cic_d decimator (settle/run/flush).
// Define CIC_D_SEQ_STATS_EN to add a saturating 16-bit underrun_cnt output port.
module cic_d_seq #(
    parameter int unsigned INP_DW  = 18,
    parameter int unsigned OUT_DW  = 18,
    parameter int unsigned CIC_R   = 10,
    parameter int unsigned CIC_N   = 7,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [INP_DW-1:0]  src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic [INP_DW-1:0]  cic_inp_data,
    output logic               cic_inp_str,
    input  logic [OUT_DW-1:0]  cic_out_data,
    input  logic               cic_out_str,
    output logic [OUT_DW-1:0]  out_data,
    output logic               out_str,
    output logic               busy,
    output logic               done,
`ifdef CIC_D_SEQ_STATS_EN
    output logic               underrun,
    output logic [15:0]        underrun_cnt
`else
    output logic               underrun
`endif
);

    localparam int unsigned SLOT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SET_W     = $clog2(CIC_N + 1);
    localparam int unsigned FLUSH_LEN = CIC_N * CIC_R;
    localparam int unsigned FL_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(CIC_N - 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [SET_W-1:0]   set_cnt;
    logic [FL_W-1:0]    fl_cnt;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] out_cnt;
    logic [BURST_W-1:0] out_cnt_inc;
    logic               tick;
    logic               start_ok;
    logic               settle_hit;
    logic               burst_hit;
    logic               flush_hit;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = SETTLE;
            SETTLE:  if (stop) state_nxt = FLUSH;
                     else if (settle_hit) state_nxt = RUN;
            RUN:     if (stop || burst_hit) state_nxt = FLUSH;
            FLUSH:   if (flush_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick        = (state != IDLE) && (slot_cnt == SLOT_LAST);
        start_ok    = (state == IDLE) && start && !stop;
        out_cnt_inc = out_cnt + 1'b1;
        settle_hit  = (state == SETTLE) && cic_out_str && (set_cnt == SET_LAST);
        burst_hit   = (state == RUN) && cic_out_str && (burst_q != '0) && (out_cnt_inc == burst_q);
        flush_hit   = (state == FLUSH) && tick && (fl_cnt == FL_LAST);
        busy        = (state != IDLE);
        src_ready   = tick && (state != FLUSH);
    end

    // Slot counter idles at zero, so the first tick lands CLK_DIV clocks after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            set_cnt  <= '0;
            fl_cnt   <= '0;
            burst_q  <= '0;
            out_cnt  <= '0;
        end else begin
            if (state == IDLE || tick) slot_cnt <= '0;
            else                       slot_cnt <= slot_cnt + 1'b1;

            if (state != SETTLE)  set_cnt <= '0;
            else if (cic_out_str) set_cnt <= set_cnt + 1'b1;

            if (state != FLUSH) fl_cnt <= '0;
            else if (tick)      fl_cnt <= fl_cnt + 1'b1;

            if (start_ok) burst_q <= burst_len;

            if (state != RUN)                         out_cnt <= '0;
            else if (cic_out_str && (out_cnt != '1)) out_cnt <= out_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cic_inp_data <= '0;
            cic_inp_str  <= 1'b0;
            underrun     <= 1'b0;
            out_data     <= '0;
            out_str      <= 1'b0;
            done         <= 1'b0;
        end else begin
            cic_inp_str <= 1'b0;
            underrun    <= 1'b0;
            out_str     <= 1'b0;
            done        <= flush_hit;
            if (tick) begin
                cic_inp_str <= 1'b1;
                if ((state != FLUSH) && src_valid) cic_inp_data <= src_data;
                else                               cic_inp_data <= '0;
                underrun <= (state != FLUSH) && !src_valid;
            end
            if ((state == RUN) && cic_out_str) begin
                out_data <= cic_out_data;
                out_str  <= 1'b1;
            end
        end
    end

`ifdef CIC_D_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            underrun_cnt <= '0;
        end else if (tick && (state != FLUSH) && !src_valid && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cic_d_seq.sv
// Scoreboard bench for cic_d_seq: a capture-level model predicts strobes, outputs and done timing.
`timescale 1ns/1ps
module tb_cic_d_seq;

    localparam int INP_DW    = 18;
    localparam int OUT_DW    = 18;
    localparam int CIC_R     = 10;
    localparam int CIC_N     = 7;
    localparam int CLK_DIV   = 4;
    localparam int BURST_W   = 16;
    localparam int FLUSH_LEN = CIC_N * CIC_R;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic [INP_DW-1:0]  src_data = '0;
    logic               src_valid = 1'b0;
    logic               src_ready;
    logic [INP_DW-1:0]  cic_inp_data;
    logic               cic_inp_str;
    logic [OUT_DW-1:0]  cic_out_data = '0;
    logic               cic_out_str = 1'b0;
    logic [OUT_DW-1:0]  out_data;
    logic               out_str;
    logic               busy;
    logic               done;
    logic               underrun;
`ifdef CIC_D_SEQ_STATS_EN
    logic [15:0]        underrun_cnt;
    int                 exp_ucnt = 0;
`endif

    cic_d_seq #(
        .INP_DW (INP_DW),
        .OUT_DW (OUT_DW),
        .CIC_R  (CIC_R),
        .CIC_N  (CIC_N),
        .CLK_DIV(CLK_DIV),
        .BURST_W(BURST_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .burst_len    (burst_len),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .cic_inp_data (cic_inp_data),
        .cic_inp_str  (cic_inp_str),
        .cic_out_data (cic_out_data),
        .cic_out_str  (cic_out_str),
        .out_data     (out_data),
        .out_str      (out_str),
        .busy         (busy),
        .done         (done),
`ifdef CIC_D_SEQ_STATS_EN
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
`else
        .underrun     (underrun)
`endif
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Filter stand-in: one output strobe with random data, one clock after every CIC_R-th input strobe.
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (cic_inp_str === 1'b1) begin
            if (stub_cnt == CIC_R - 1) begin
                stub_cnt     <= 0;
                cic_out_str  <= 1'b1;
                cic_out_data <= 18'($urandom);
            end else begin
                stub_cnt    <= stub_cnt + 1;
                cic_out_str <= 1'b0;
            end
        end else begin
            cic_out_str <= 1'b0;
        end
    end

    typedef struct { int cyc; logic [INP_DW-1:0] data; logic und; } strb_t;
    typedef struct { int cyc; logic [OUT_DW-1:0] data; } outx_t;
    strb_t sq[$];
    outx_t oq[$];

    bit m_cap = 0;
    bit m_run_over = 0;
    int m_c0 = 0;
    int m_k = 0;
    int m_fwd = 0;
    int m_burst = 0;
    int m_fl_ticks = 0;
    bit busy_nxt = 0;
    bit ready_nxt = 0;
    bit mon_en = 0;
    int done_cyc = -1;
    int zero_cyc = -1;
    int uclr_cyc = -1;

    function automatic bit is_tick(input int m);
        return ((m - m_c0) >= CLK_DIV) && (((m - m_c0) % CLK_DIV) == 0);
    endfunction

    // Capture model: sample slots every CLK_DIV clocks, first CIC_N filter outputs dropped,
    // forwarding until burst reached or stop, then FLUSH_LEN zero slots and done.
    always @(negedge clk) begin
        strb_t s;
        outx_t o;
        if (reset) begin
            m_cap = 0;
            m_run_over = 0;
            sq.delete();
            oq.delete();
            zero_cyc = cyc + 1;
            done_cyc = -1;
            mon_en = 1;
        end else if (m_cap) begin
            if (is_tick(cyc)) begin
                s.cyc = cyc + 1;
                if (m_run_over) begin
                    s.data = '0;
                    s.und = 1'b0;
                    sq.push_back(s);
                    m_fl_ticks++;
                    if (m_fl_ticks == FLUSH_LEN) begin
                        done_cyc = cyc + 1;
                        m_cap = 0;
                    end
                end else begin
                    s.data = src_valid ? src_data : '0;
                    s.und = !src_valid;
                    sq.push_back(s);
                end
            end
            if (m_cap && cic_out_str) begin
                m_k++;
                if (m_k > CIC_N && !m_run_over) begin
                    o.cyc = cyc + 1;
                    o.data = cic_out_data;
                    oq.push_back(o);
                    m_fwd++;
                    if (m_burst != 0 && m_fwd == m_burst) m_run_over = 1;
                end
            end
            if (m_cap && stop && !m_run_over) m_run_over = 1;
        end else if (start && !stop) begin
            m_cap = 1;
            m_c0 = cyc;
            m_k = 0;
            m_fwd = 0;
            m_run_over = 0;
            m_fl_ticks = 0;
            m_burst = int'(burst_len);
            uclr_cyc = cyc + 1;
        end
        busy_nxt = m_cap;
        ready_nxt = m_cap && !m_run_over && is_tick(cyc + 1);
    end

    logic [INP_DW-1:0] hold_inp = '0;
    logic [OUT_DW-1:0] hold_out = '0;
    int mon_outs = 0;
    int mon_unds = 0;

    initial forever begin
        bit exp_str;
        bit exp_out;
        bit exp_und;
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (cyc == zero_cyc) begin
                hold_inp = '0;
                hold_out = '0;
`ifdef CIC_D_SEQ_STATS_EN
                exp_ucnt = 0;
`endif
            end
`ifdef CIC_D_SEQ_STATS_EN
            if (cyc == uclr_cyc) exp_ucnt = 0;
`endif
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                chk("inp_strobe_slot", cyc, sq[0].cyc);
                void'(sq.pop_front());
            end
            while (oq.size() > 0 && oq[0].cyc < cyc) begin
                chk("out_strobe_slot", cyc, oq[0].cyc);
                void'(oq.pop_front());
            end
            exp_str = (sq.size() > 0) && (sq[0].cyc == cyc);
            exp_und = 1'b0;
            if (exp_str) begin
                hold_inp = sq[0].data;
                exp_und = sq[0].und;
                void'(sq.pop_front());
            end
            chk("cic_inp_str", cic_inp_str, exp_str);
            chk("cic_inp_data", cic_inp_data, hold_inp);
            chk("underrun", underrun, exp_und);
            exp_out = (oq.size() > 0) && (oq[0].cyc == cyc);
            if (exp_out) begin
                hold_out = oq[0].data;
                void'(oq.pop_front());
            end
            chk("out_str", out_str, exp_out);
            chk("out_data", out_data, hold_out);
            chk("done", done, cyc == done_cyc);
            chk("busy", busy, busy_nxt);
            chk("src_ready", src_ready, ready_nxt);
`ifdef CIC_D_SEQ_STATS_EN
            if (exp_und && exp_ucnt < 65535) exp_ucnt++;
            chk("underrun_cnt", underrun_cnt, exp_ucnt);
`endif
            if (out_str === 1'b1) mon_outs++;
            if (underrun === 1'b1) mon_unds++;
        end
    end

    // 0: constant valid 1000; 1: random data, ~1/8 slots missing; 2: random data, only slot 20 missing.
    int src_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (src_mode)
            0: begin
                src_valid = 1'b1;
                src_data = 18'd1000;
            end
            1: begin
                src_valid = ($urandom_range(7) != 0);
                src_data = 18'($urandom);
            end
            default: begin
                src_valid = !(m_cap && is_tick(cyc) && ((cyc - m_c0) / CLK_DIV == 20));
                src_data = 18'($urandom);
            end
        endcase
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (m_cap && n < bound) begin
            step(1);
            n++;
        end
        if (m_cap) begin
            checks++;
            errors++;
            $display("FAIL %s: capture still running after %0d cycles", name, bound);
        end
        step(3);
    endtask

    task automatic wait_outs(input int want, input int bound, input string name);
        int n = 0;
        while (mon_outs < want && n < bound) begin
            step(1);
            n++;
        end
        if (mon_outs < want) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d outputs expected %0d within %0d cycles", name, mon_outs, want, bound);
        end
    endtask

    task automatic kick(input int len);
        burst_len = 16'(len);
        mon_outs = 0;
        mon_unds = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b1;
        step(3);
        reset = 1'b0;
        start = 1'b0;
        step(50);

        src_mode = 0;
        kick(5);
        wait_idle(3000, "burst_idle");
        chk("burst_outputs", mon_outs, 5);
        chk("burst_underruns", mon_unds, 0);
        chk("burst_outq_left", oq.size(), 0);

        src_mode = 2;
        kick(0);
        wait_outs(3, 2000, "stop_wait");
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_idle(1000, "stop_idle");
        chk("stop_outputs", mon_outs, 3);
        chk("stop_underruns", mon_unds, 1);
`ifdef CIC_D_SEQ_STATS_EN
        chk("stop_underrun_cnt", underrun_cnt, 1);
`endif

        src_mode = 1;
        burst_len = 16'd3;
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        step(20);
        chk("race_busy", busy, 0);

        kick(4);
        wait_outs(2, 2000, "race_wait");
        burst_len = 16'd9;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle(2000, "race_idle");
        chk("race_outputs", mon_outs, 4);

        for (int r = 0; r < 2; r++) begin
            kick(int'($urandom_range(6, 1)));
            wait_idle(3000, "rand_idle");
            chk("rand_outputs", mon_outs, m_burst);
        end

        kick(2);
        n = 0;
        while (!(m_run_over && m_fl_ticks >= 30) && n < 3000) begin
            step(1);
            n++;
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);
        chk("rst_flush_busy", busy, 0);
        chk("rst_flush_outputs", mon_outs, 2);

        kick(3);
        wait_idle(3000, "post_rst_idle");
        chk("post_rst_outputs", mon_outs, 3);
        chk("post_rst_outq_left", oq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
